axi_rd_route_tracker: RTL and testbench
=======================================

// Module: axi_rd_route_tracker
// PURPOSE
//   Tracks which of 4 slaves owns each outstanding read burst of one master; drives the 2-bit
//   slave select for the master-side R-channel mux and the 1x4 RREADY demux. Sits on the
//   master's AR path (address decode + gating) and on its R path (burst retirement on RLAST).
//   In-order FIFO of selects; head entry is the slave currently allowed to return R data.
// PARAMETERS
//   ADDR_WIDTH  32  AR address width
//   SEL_LSB     30  slave index = ar_addr[SEL_LSB+1:SEL_LSB]; must be <= ADDR_WIDTH-2
//   FIFO_DEPTH  4   max outstanding read bursts; power of 2, >= 2
// PORTS
//   ACLK         in   1           clock, all logic on rising edge
//   ARESET       in   1           synchronous reset, active-high
//   ar_addr      in   ADDR_WIDTH  master ARADDR
//   ar_len       in   8           master ARLEN (used only with RD_BEAT_CHK_EN)
//   ar_valid_in  in   1           master ARVALID
//   ar_ready_out out  1           ARREADY returned to master
//   ar_valid_out out  1           ARVALID forwarded to AR arbiter/slave side
//   ar_ready_in  in   1           ARREADY from AR arbiter/slave side
//   r_valid      in   1           RVALID after slave-side mux
//   r_ready      in   1           master RREADY (before demux)
//   r_last       in   1           RLAST after slave-side mux
//   rd_sel       out  2           slave select for R mux/RREADY demux
//   rd_sel_valid out  1           1 = rd_sel refers to a live burst
//   outstanding  out  clog2(D)+1  number of bursts in flight
//   err_unexp_r  out  1           sticky: R beat accepted with no burst in flight
//   err_len      out  1           sticky: RLAST/beat-count mismatch (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (ARESET=1 at edge): wr/rd pointers, count, errors, beat counter -> 0. Outputs after
//     reset: rd_sel=0, rd_sel_valid=0, outstanding=0, err_*=0. While ARESET=1, ar_valid_out
//     and ar_ready_out are forced 0 combinationally. Reset mid-burst discards all entries.
//   - full = (count==FIFO_DEPTH); empty = (count==0).
//   - ar_valid_out = ar_valid_in & ~full; ar_ready_out = ar_ready_in & ~full (combinational,
//     no bubble). Full blocks AR even if a pop occurs the same cycle (no push/pop bypass).
//   - push = ar_valid_out & ar_ready_in: store ar_addr[SEL_LSB+1:SEL_LSB] (and ar_len) at wr_ptr.
//   - pop  = r_valid & r_ready & r_last & ~empty: retire head, advance rd_ptr.
//   - Pointers wrap modulo FIFO_DEPTH; count +1 on push only, -1 on pop only, unchanged on both.
//   - rd_sel = mem[rd_ptr] when ~empty, else 2'b00; rd_sel_valid = ~empty. Both driven from
//     registers: a push into an empty FIFO is visible the following cycle (1-cycle latency);
//     after pop the next head is visible the following cycle.
//   - Simultaneous push+pop with count==1: head advances to pushed entry, count stays 1.
//   - r_valid & r_ready while empty: no pop, err_unexp_r set (sticky until reset).
//   - No throttling of R: this block never drives RREADY/RVALID.
// CONFIGURATION
//   RD_BEAT_CHK_EN defined: FIFO also stores ar_len; 8-bit beat counter counts accepted R beats
//     (r_valid & r_ready & ~empty) of head burst, cleared on pop and reset. err_len set (sticky)
//     if r_last accepted with beat!=len, or beat==len accepted without r_last. Pop still
//     occurs only on r_last.
//   RD_BEAT_CHK_EN undefined: no len storage/counter; ar_len ignored; err_len tied 0.
// TESTING
//   1 Reset: ARESET=1 3 cycles w/ ar_valid_in=1 -> ar_valid_out=0, rd_sel_valid=0, outstanding=0.
//   2 AR addr 0x8000_0000 accepted, then 4-beat burst r_last on beat 4 -> rd_sel=2'b10 valid
//     cycle after AR handshake; outstanding 1->0 cycle after RLAST beat.
//   3 Push 4 ARs (sel 0,1,2,3) w/ FIFO_DEPTH=4 -> 5th AR: ar_ready_out=0, ar_valid_out=0; after
//     one RLAST pop, 5th accepted next cycle; rd_sel sequence 0,1,2,3 then wraps.
//   4 count==1, push (sel 3) and RLAST pop same cycle -> outstanding stays 1, rd_sel=3 next cycle.
//   5 r_valid&r_ready with empty FIFO -> err_unexp_r=1 and stays 1 until ARESET.
//   6 RD_BEAT_CHK_EN: ar_len=3, r_last on beat 2 -> err_len=1, entry popped; undefined -> err_len=0.

Source files
------------

// File: rtl/axi_rd_route_tracker.sv
// Read-burst route tracker: in-order FIFO of slave selects driving the R-channel mux/RREADY demux.
// Optional per-burst beat-count checking is enabled by defining RD_BEAT_CHK_EN.
module axi_rd_route_tracker #(
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_LSB    = 30,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic [ADDR_WIDTH-1:0]       ar_addr,
  input  logic [7:0]                  ar_len,
  input  logic                        ar_valid_in,
  output logic                        ar_ready_out,
  output logic                        ar_valid_out,
  input  logic                        ar_ready_in,
  input  logic                        r_valid,
  input  logic                        r_ready,
  input  logic                        r_last,
  output logic [1:0]                  rd_sel,
  output logic                        rd_sel_valid,
  output logic [$clog2(FIFO_DEPTH):0] outstanding,
  output logic                        err_unexp_r,
  output logic                        err_len
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       sel_mem [FIFO_DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic r_acc;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Gating is purely combinational so an accepting slave sees no extra bubble;
  // a full FIFO blocks AR even in a cycle where the head retires.
  assign ar_valid_out = ~ARESET & ar_valid_in & ~full;
  assign ar_ready_out = ~ARESET & ar_ready_in & ~full;

  assign push  = ar_valid_out & ar_ready_in;
  assign r_acc = r_valid & r_ready;
  assign pop   = r_acc & r_last & ~empty;

  // NOTE: sel_mem holds only payload guarded by count, so it needs no reset;
  // keeping it reset-free lets it map onto plain storage.
  always_ff @(posedge ACLK) begin
    if (push) begin
      sel_mem[wr_ptr] <= ar_addr[SEL_LSB+1:SEL_LSB];
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_unexp_r <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (r_acc && empty) err_unexp_r <= 1'b1;
    end
  end

  assign rd_sel       = empty ? 2'b00 : sel_mem[rd_ptr];
  assign rd_sel_valid = ~empty;
  assign outstanding  = count;

`ifdef RD_BEAT_CHK_EN
  logic [7:0] len_mem [FIFO_DEPTH];
  logic [7:0] beat_cnt;
  logic [7:0] head_len;
  logic       beat_acc;
  logic       len_bad;

  always_ff @(posedge ACLK) begin
    if (push) begin
      len_mem[wr_ptr] <= ar_len;
    end
  end

  // beat_cnt is the 0-based index of the head burst's next beat; ARLEN is the
  // index of its last beat, so RLAST must coincide exactly with beat_cnt==len.
  assign head_len = len_mem[rd_ptr];
  assign beat_acc = r_acc & ~empty;
  assign len_bad  = beat_acc & (r_last ? (beat_cnt != head_len) : (beat_cnt == head_len));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      beat_cnt <= '0;
      err_len  <= 1'b0;
    end else begin
      if (pop)           beat_cnt <= '0;
      else if (beat_acc) beat_cnt <= beat_cnt + 1'b1;
      if (len_bad) err_len <= 1'b1;
    end
  end
`else
  assign err_len = 1'b0;
`endif

  // Address bits outside the select field (and ar_len when unchecked) are
  // intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{ar_addr, ar_len};

endmodule

// File: tb/tb_axi_rd_route_tracker.sv
// Self-checking bench for axi_rd_route_tracker: per-cycle vector table plus directed
// sequences for reset, unexpected-R and beat-length corner cases.
module tb_axi_rd_route_tracker;

  localparam int ADDR_WIDTH = 32;
  localparam int SEL_LSB    = 30;
  localparam int FIFO_DEPTH = 4;

`ifdef RD_BEAT_CHK_EN
  localparam logic EXP_LEN_ERR = 1'b1;
`else
  localparam logic EXP_LEN_ERR = 1'b0;
`endif

  logic                  ACLK;
  logic                  ARESET;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic                  ar_valid_in;
  logic                  ar_ready_out;
  logic                  ar_valid_out;
  logic                  ar_ready_in;
  logic                  r_valid;
  logic                  r_ready;
  logic                  r_last;
  logic [1:0]            rd_sel;
  logic                  rd_sel_valid;
  logic [2:0]            outstanding;
  logic                  err_unexp_r;
  logic                  err_len;

  int n_checks = 0;
  int n_fail   = 0;

  axi_rd_route_tracker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .SEL_LSB   (SEL_LSB),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .ar_addr     (ar_addr),
    .ar_len      (ar_len),
    .ar_valid_in (ar_valid_in),
    .ar_ready_out(ar_ready_out),
    .ar_valid_out(ar_valid_out),
    .ar_ready_in (ar_ready_in),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .r_last      (r_last),
    .rd_sel      (rd_sel),
    .rd_sel_valid(rd_sel_valid),
    .outstanding (outstanding),
    .err_unexp_r (err_unexp_r),
    .err_len     (err_len)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct {
    logic       avi;
    logic       ari;
    logic [1:0] sel;
    logic [7:0] len;
    logic       rv;
    logic       rr;
    logic       rl;
    logic       e_avo;
    logic       e_aro;
    logic [1:0] e_sel;
    logic       e_selv;
    logic [2:0] e_out;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs are then driven/sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive(input logic avi, input logic ari, input logic [1:0] sel,
                       input logic [7:0] len, input logic rv, input logic rr, input logic rl);
    ar_valid_in = avi;
    ar_ready_in = ari;
    ar_addr     = {sel, 30'h0};
    ar_len      = len;
    r_valid     = rv;
    r_ready     = rr;
    r_last      = rl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    idle();
    tick();
    ARESET = 1'b0;
  endtask

  function automatic vec_t mk(input logic avi, input logic ari, input logic [1:0] sel,
                              input logic [7:0] len, input logic rv, input logic rr,
                              input logic rl, input logic e_avo, input logic e_aro,
                              input logic [1:0] e_sel, input logic e_selv,
                              input logic [2:0] e_out);
    vec_t v;
    v.avi = avi; v.ari = ari; v.sel = sel; v.len = len;
    v.rv = rv; v.rr = rr; v.rl = rl;
    v.e_avo = e_avo; v.e_aro = e_aro; v.e_sel = e_sel; v.e_selv = e_selv; v.e_out = e_out;
    return v;
  endfunction

  initial begin
    // Expected outputs are those visible before the vector's clock edge.
    //               avi ari sel  len  rv rr rl  avo aro sel selv out
    // single 4-beat burst to slave 2
    vecs[0]  = mk(1, 1, 2'd2, 8'd3, 0, 0, 0,  1, 1, 2'd0, 0, 3'd0);
    vecs[1]  = mk(0, 0, 2'd0, 8'd0, 0, 0, 0,  0, 0, 2'd2, 1, 3'd1);
    vecs[2]  = mk(0, 0, 2'd0, 8'd0, 1, 1, 0,  0, 0, 2'd2, 1, 3'd1);
    vecs[3]  = mk(0, 0, 2'd0, 8'd0, 1, 1, 0,  0, 0, 2'd2, 1, 3'd1);
    vecs[4]  = mk(0, 0, 2'd0, 8'd0, 1, 1, 0,  0, 0, 2'd2, 1, 3'd1);
    vecs[5]  = mk(0, 0, 2'd0, 8'd0, 1, 1, 1,  0, 0, 2'd2, 1, 3'd1);
    vecs[6]  = mk(0, 0, 2'd0, 8'd0, 0, 0, 0,  0, 0, 2'd0, 0, 3'd0);
    // fill to FIFO_DEPTH with sel 0..3, single-beat bursts
    vecs[7]  = mk(1, 1, 2'd0, 8'd0, 0, 0, 0,  1, 1, 2'd0, 0, 3'd0);
    vecs[8]  = mk(1, 1, 2'd1, 8'd0, 0, 0, 0,  1, 1, 2'd0, 1, 3'd1);
    vecs[9]  = mk(1, 1, 2'd2, 8'd0, 0, 0, 0,  1, 1, 2'd0, 1, 3'd2);
    vecs[10] = mk(1, 1, 2'd3, 8'd0, 0, 0, 0,  1, 1, 2'd0, 1, 3'd3);
    // fifth AR blocked while full, also in the pop cycle
    vecs[11] = mk(1, 1, 2'd1, 8'd0, 0, 0, 0,  0, 0, 2'd0, 1, 3'd4);
    vecs[12] = mk(1, 1, 2'd1, 8'd0, 1, 1, 1,  0, 0, 2'd0, 1, 3'd4);
    vecs[13] = mk(1, 1, 2'd1, 8'd0, 0, 0, 0,  1, 1, 2'd1, 1, 3'd3);
    // drain: heads 1,2,3 then wrapped entry
    vecs[14] = mk(0, 0, 2'd0, 8'd0, 1, 1, 1,  0, 0, 2'd1, 1, 3'd4);
    vecs[15] = mk(0, 0, 2'd0, 8'd0, 1, 1, 1,  0, 0, 2'd2, 1, 3'd3);
    vecs[16] = mk(0, 0, 2'd0, 8'd0, 1, 1, 1,  0, 0, 2'd3, 1, 3'd2);
    // count==1: push sel 3 and pop together
    vecs[17] = mk(1, 1, 2'd3, 8'd0, 1, 1, 1,  1, 1, 2'd1, 1, 3'd1);
    vecs[18] = mk(0, 0, 2'd0, 8'd0, 0, 0, 0,  0, 0, 2'd3, 1, 3'd1);
    vecs[19] = mk(0, 0, 2'd0, 8'd0, 1, 1, 1,  0, 0, 2'd3, 1, 3'd1);
    vecs[20] = mk(0, 0, 2'd0, 8'd0, 0, 0, 0,  0, 0, 2'd0, 0, 3'd0);

    // Reset held 3 cycles with AR requests active
    ARESET = 1'b1;
    drive(1'b1, 1'b1, 2'd3, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_ar_valid_out", 32'(ar_valid_out), 32'd0);
      check("rst_ar_ready_out", 32'(ar_ready_out), 32'd0);
      check("rst_rd_sel_valid", 32'(rd_sel_valid), 32'd0);
      check("rst_outstanding",  32'(outstanding),  32'd0);
    end
    check("rst_rd_sel",      32'(rd_sel),      32'd0);
    check("rst_err_unexp_r", 32'(err_unexp_r), 32'd0);
    check("rst_err_len",     32'(err_len),     32'd0);
    ARESET = 1'b0;
    idle();

    // Table-driven main sequence
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].avi, vecs[i].ari, vecs[i].sel, vecs[i].len,
            vecs[i].rv, vecs[i].rr, vecs[i].rl);
      #1;
      check($sformatf("v%0d_ar_valid_out", i), 32'(ar_valid_out), 32'(vecs[i].e_avo));
      check($sformatf("v%0d_ar_ready_out", i), 32'(ar_ready_out), 32'(vecs[i].e_aro));
      check($sformatf("v%0d_rd_sel", i),       32'(rd_sel),       32'(vecs[i].e_sel));
      check($sformatf("v%0d_rd_sel_valid", i), 32'(rd_sel_valid), 32'(vecs[i].e_selv));
      check($sformatf("v%0d_outstanding", i),  32'(outstanding),  32'(vecs[i].e_out));
      check($sformatf("v%0d_err_unexp_r", i),  32'(err_unexp_r),  32'd0);
      check($sformatf("v%0d_err_len", i),      32'(err_len),      32'd0);
      tick();
    end

    // Unexpected R beat on empty FIFO sets a sticky error
    idle();
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    check("unexp_set", 32'(err_unexp_r), 32'd1);
    check("unexp_no_pop", 32'(outstanding), 32'd0);
    for (int c = 0; c < 3; c++) tick();
    check("unexp_sticky", 32'(err_unexp_r), 32'd1);
    // Leave a burst in flight, then reset mid-burst
    drive(1'b1, 1'b1, 2'd1, 8'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    tick();
    check("midburst_outstanding", 32'(outstanding), 32'd1);
    check("midburst_rd_sel",      32'(rd_sel),      32'd1);
    do_reset();
    #1;
    check("postrst_outstanding",  32'(outstanding),  32'd0);
    check("postrst_rd_sel_valid", 32'(rd_sel_valid), 32'd0);
    check("postrst_err_unexp_r",  32'(err_unexp_r),  32'd0);

    // Early RLAST: ar_len=3, RLAST on the second beat
    drive(1'b1, 1'b1, 2'd2, 8'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    tick();
    check("early_no_err_yet", 32'(err_len), 32'd0);
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    check("early_err_len",     32'(err_len),     32'(EXP_LEN_ERR));
    check("early_popped",      32'(outstanding), 32'd0);
    check("early_err_unexp_r", 32'(err_unexp_r), 32'd0);

    // Missing RLAST: ar_len=1, final beat arrives without RLAST
    do_reset();
    drive(1'b1, 1'b1, 2'd3, 8'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 1'b0);
    tick();
    check("late_no_err_yet", 32'(err_len), 32'd0);
    tick();
    idle();
    check("late_err_len",    32'(err_len),     32'(EXP_LEN_ERR));
    check("late_still_open", 32'(outstanding), 32'd1);
    check("late_rd_sel",     32'(rd_sel),      32'd3);
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    check("late_popped", 32'(outstanding), 32'd0);
    check("late_sticky", 32'(err_len),     32'(EXP_LEN_ERR));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
